// File: rtl/regfile_clr_pkg.sv
// Shared register-file defines, FSM encoding and sizing for regfile_clr.
// Optional feature macro: REGFILE_PARITY_EN (adds one even-parity bit per register).
`ifndef REGFILE_CLR_DEFINES
`define REGFILE_CLR_DEFINES
`define RegBus       31:0
`define RegAddrBus   4:0
`define RegNum       32
`define ZeroWord     32'h0000_0000
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`define ReadEnable   1'b1
`define ReadDisable  1'b0
`define RF_CLEAR     1'b0
`define RF_READY     1'b1
`endif

package regfile_clr_pkg;
  localparam int NREG = `RegNum;
  localparam int AW   = $clog2(NREG);
  localparam int DW   = 32;
`ifdef REGFILE_PARITY_EN
  localparam int SW   = DW + 1;
`else
  localparam int SW   = DW;
`endif

  typedef enum logic {
    ST_CLEAR = `RF_CLEAR,
    ST_READY = `RF_READY
  } rf_state_e;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [DW-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/regfile_clr_if.sv
// Write-back / decode-read bus of the register file.
// Handshake: no valid/ready; reads are combinational and writes take effect on the edge with we=1.
interface regfile_clr_if
  import regfile_clr_pkg::*;
#(
  parameter int A_W = AW,
  parameter int D_W = DW
);
  logic           we;
  logic [A_W-1:0] waddr;
  logic [D_W-1:0] wdata;
  logic           re1;
  logic [A_W-1:0] raddr1;
  logic [D_W-1:0] rdata1;
  logic           re2;
  logic [A_W-1:0] raddr2;
  logic [D_W-1:0] rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile_clr_rdport.sv
// One combinational read port: masking, same-cycle write bypass and optional parity check.
module regfile_rdport
  import regfile_clr_pkg::*;
#(
  parameter int A_W = AW,
  parameter int D_W = DW,
  parameter int S_W = SW
) (
  input  logic           rst,
  input  logic           ready,
  input  logic           re,
  input  logic [A_W-1:0] raddr,
  input  logic           we,
  input  logic [A_W-1:0] waddr,
  input  logic [D_W-1:0] wdata,
  input  logic [S_W-1:0] word,
  output logic [D_W-1:0] rdata,
  output logic           err
);
  always_comb begin
    rdata = '0;
    err   = 1'b0;
    if (!rst && ready && re && (raddr != '0)) begin
      if (we && (waddr == raddr)) begin
        rdata = wdata;
      end else begin
        rdata = word[D_W-1:0];
`ifdef REGFILE_PARITY_EN
        // Data plus its stored even-parity bit must have an even number of ones.
        err = ^word;
`endif
      end
    end
  end
endmodule

// File: rtl/regfile_clr.sv
// General-purpose register file with post-reset clear sequencer and write-to-read bypass.
// Optional feature macro: REGFILE_PARITY_EN (sticky parity error on perr_o).
module regfile_clr
  import regfile_clr_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  regfile_clr_if.slave bus,
  output logic         ready_o,
  output logic         stallreq_o,
  output logic         perr_o
);
  rf_state_e         state, state_next;
  logic [AW-1:0]     ptr, ptr_next;
  logic              clear_en;
  logic [SW-1:0]     regs [NREG];
  logic [SW-1:0]     wword;
  logic              err1, err2;
  logic              perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      ptr   <= AW'(1);
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // The clear walks $1..$NREG-1 and hands over to READY after the last one.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    clear_en   = 1'b0;
    case (state)
      ST_CLEAR: begin
        clear_en = 1'b1;
        ptr_next = ptr + AW'(1);
        if (ptr == AW'(NREG - 1)) state_next = ST_READY;
      end
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_CLEAR;
    endcase
  end

  assign ready_o    = (state == ST_READY);
  assign stallreq_o = ~ready_o;

`ifdef REGFILE_PARITY_EN
  assign wword = {even_parity(bus.wdata), bus.wdata};
`else
  assign wword = bus.wdata;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_en) begin
        regs[ptr] <= '0;
      end else if (bus.we && (bus.waddr != '0)) begin
        regs[bus.waddr] <= wword;
      end
    end
  end

  regfile_rdport #(.A_W(AW), .D_W(DW), .S_W(SW)) u_rd1 (
    .rst   (rst),
    .ready (ready_o),
    .re    (bus.re1),
    .raddr (bus.raddr1),
    .we    (bus.we),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
    .word  (regs[bus.raddr1]),
    .rdata (bus.rdata1),
    .err   (err1)
  );

  regfile_rdport #(.A_W(AW), .D_W(DW), .S_W(SW)) u_rd2 (
    .rst   (rst),
    .ready (ready_o),
    .re    (bus.re2),
    .raddr (bus.raddr2),
    .we    (bus.we),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
    .word  (regs[bus.raddr2]),
    .rdata (bus.rdata2),
    .err   (err2)
  );

  // Without parity both error bits are constant 0, so this flag never sets.
  always_ff @(posedge clk) begin
    if (rst)               perr <= 1'b0;
    else if (err1 | err2)  perr <= 1'b1;
  end

  assign perr_o = perr;
endmodule

// File: tb/tb_regfile_clr.sv
// Randomized scoreboard bench for regfile_clr against a per-register behavioural model.
module tb_regfile_clr;
  import regfile_clr_pkg::*;

  localparam int W = 2 * DW + 3;

  logic clk;
  logic rst;
  logic ready_o, stallreq_o, perr_o;

  regfile_clr_if bus ();

  regfile_clr dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o),
    .perr_o     (perr_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [DW-1:0] mdl [NREG];
  bit            bad [NREG];
  bit            m_ready;
  bit            m_perr;
  int            clr_cnt;

  // scoreboard
  logic [W-1:0] exp_q [$];
  int n_cmp;
  int n_err;
  int cyc;

  function automatic logic [DW-1:0] exp_read(input bit r, input bit re, input logic [AW-1:0] ra,
                                             input bit we, input logic [AW-1:0] wa,
                                             input logic [DW-1:0] wd);
    if (r || !m_ready || !re || ra == 0) return '0;
    if (we && wa == ra) return wd;
    return mdl[ra];
  endfunction

  task automatic step(input bit r, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit re1, input logic [AW-1:0] ra1,
                      input bit re2, input logic [AW-1:0] ra2);
    logic [DW-1:0] e1, e2;
    rst        = r;
    bus.we     = we;
    bus.waddr  = wa;
    bus.wdata  = wd;
    bus.re1    = re1;
    bus.raddr1 = ra1;
    bus.re2    = re2;
    bus.raddr2 = ra2;
    e1 = exp_read(r, re1, ra1, we, wa, wd);
    e2 = exp_read(r, re2, ra2, we, wa, wd);
    exp_q.push_back({e1, e2, m_ready, ~m_ready, m_perr});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NREG; i++) begin
        mdl[i] = '0;
        bad[i] = 1'b0;
      end
      m_ready = 1'b0;
      m_perr  = 1'b0;
      clr_cnt = 0;
    end else if (!m_ready) begin
      clr_cnt++;
      if (clr_cnt == NREG - 1) m_ready = 1'b1;
    end else begin
`ifdef REGFILE_PARITY_EN
      if (re1 && ra1 != 0 && !(we && wa == ra1) && bad[ra1]) m_perr = 1'b1;
      if (re2 && ra2 != 0 && !(we && wa == ra2) && bad[ra2]) m_perr = 1'b1;
`endif
      if (we && wa != 0) begin
        mdl[wa] = wd;
        bad[wa] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rnd_step(input int rst_odds);
    step(($urandom_range(0, rst_odds) == 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
         $urandom, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
         1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)));
  endtask

  // monitor: outputs are sampled mid-cycle, away from the rising edge
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = {bus.rdata1, bus.rdata2, ready_o, stallreq_o, perr_o};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL cyc%0d port_check: rdata1=%h/%h rdata2=%h/%h ready=%b/%b stall=%b/%b perr=%b/%b (got/exp)",
                 cyc, got[W-1 -: DW], exp[W-1 -: DW], got[DW+2 : 3], exp[DW+2 : 3],
                 got[2], exp[2], got[1], exp[1], got[0], exp[0]);
      end
    end
    cyc++;
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    m_ready = 1'b0;
    m_perr  = 1'b0;
    clr_cnt = 0;
    for (int i = 0; i < NREG; i++) begin
      mdl[i] = '0;
      bad[i] = 1'b0;
    end
    rst = 1'b1;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;
    @(posedge clk);
    #1;

    // one reset cycle, 31 clear cycles with live reads, then a full read sweep
    step(1'b1, 1'b0, '0, '0, 1'b1, AW'(1), 1'b1, AW'(2));
    for (int i = 0; i < NREG - 1; i++) rnd_step(1 << 30);
    for (int i = 0; i < NREG; i++)
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 1'b1, AW'(NREG - 1 - i));

    // write then read, with the other port disabled
    step(1'b0, 1'b1, AW'(3), 32'h1234_5678, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(3), 1'b0, AW'(3));
    // same-cycle bypass on both ports
    step(1'b0, 1'b1, AW'(7), 32'hDEAD_BEEF, 1'b1, AW'(7), 1'b1, AW'(7));
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(7), 1'b1, AW'(3));
    // $0 is never written and never bypassed
    step(1'b0, 1'b1, AW'(0), 32'hFFFF_FFFF, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(0), 1'b1, AW'(0));
    step(1'b0, 1'b1, AW'(0), 32'hFFFF_FFFF, 1'b1, AW'(0), 1'b1, AW'(0));

    // reset partway through a clear restarts it; writes during clear are dropped
    step(1'b0, 1'b1, AW'(5), 32'hA5A5_A5A5, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b1, AW'(5), 1'b0, '0);
    for (int i = 0; i < 9; i++)
      step(1'b0, 1'b1, AW'(5), $urandom, 1'b1, AW'(5), 1'b1, AW'($urandom_range(0, NREG - 1)));
    step(1'b1, 1'b1, AW'(5), 32'h5A5A_5A5A, 1'b1, AW'(5), 1'b0, '0);
    for (int i = 0; i < NREG - 1; i++)
      step(1'b0, 1'b1, AW'($urandom_range(1, NREG - 1)), $urandom, 1'b1, AW'(5), 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), 1'b1, AW'(5));

`ifdef REGFILE_PARITY_EN
    // corrupt the stored parity bit of $9 and check the sticky error
    step(1'b0, 1'b1, AW'(9), 32'h1, 1'b0, '0, 1'b0, '0);
    dut.regs[9][DW] = ~dut.regs[9][DW];
    bad[9] = 1'b1;
    step(1'b0, 1'b0, '0, '0, 1'b1, AW'(9), 1'b0, '0);
    for (int i = 0; i < 3; i++) idle();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    idle();
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) rnd_step(250);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
